// File: rtl/ram1_uart_arbiter.sv
// RAM1 bus arbiter: shares the SRAM data bus between CPU SRAM accesses and the CPLD UART.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed UART-first priority.
module ram1_uart_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int SRAM_WAIT  = 2,
    parameter int UART_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [3:0]        m_be,
    input  logic [31:0]       m_wdata,
    output logic [31:0]       m_rdata,
    output logic              m_ack,
    input  logic              u_req,
    input  logic              u_we,
    input  logic              u_sel,
    input  logic [7:0]        u_wdata,
    output logic [31:0]       u_rdata,
    output logic              u_ack,
    inout  wire  [31:0]       ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              uart_wrn,
    output logic              uart_rdn,
    input  logic              uart_tbre,
    input  logic              uart_tsre,
    input  logic              uart_dataready
);

    // state  | meaning
    // IDLE   | waiting for a request, grant decided here
    // S_ACC  | SRAM cycle, ce_n low for SRAM_WAIT cycles
    // U_WSET | UART write data setup, wrn high
    // U_WPUL | UART write strobe, wrn low for UART_PULSE cycles
    // U_TBRE | wait for transmit buffer empty
    // U_TSRE | wait for transmit shift register empty
    // U_RPUL | wait for dataready, then rdn low for UART_PULSE cycles
    // U_RLAT | rdn released after byte capture
    // DONE   | one-cycle ack to the owning port
    typedef enum logic [3:0] {
        IDLE, S_ACC, U_WSET, U_WPUL, U_TBRE, U_TSRE, U_RPUL, U_RLAT, DONE
    } state_t;

    localparam int CW = 8;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_owner_u;
    logic                r_we;
    logic                r_rd_active;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be_n;
    logic [31:0]         r_m_rdata;
    logic [31:0]         r_u_rdata;
    logic                w_grant_u;
    logic                w_drive;

`ifdef ARB_ROUND_ROBIN_EN
    logic                r_last_u;
    always_comb w_grant_u = u_req && (!m_req || !r_last_u);
`else
    always_comb w_grant_u = u_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_u)  w_next = u_sel ? DONE : (u_we ? U_WSET : U_RPUL);
                else if (m_req) w_next = S_ACC;
            end
            S_ACC:   if (r_cnt == '0) w_next = DONE;
            U_WSET:  w_next = U_WPUL;
            U_WPUL:  if (r_cnt == '0) w_next = U_TBRE;
            U_TBRE:  if (uart_tbre) w_next = U_TSRE;
            U_TSRE:  if (uart_tsre) w_next = DONE;
            U_RPUL:  if (r_rd_active && r_cnt == '0) w_next = U_RLAT;
            U_RLAT:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // we_n releases one cycle before ce_n so the write completes with data still held
    always_comb begin
        ram_ce_n = !(r_state == S_ACC);
        ram_oe_n = !(r_state == S_ACC && !r_we);
        ram_we_n = !(r_state == S_ACC && r_we && (r_cnt != '0 || SRAM_WAIT == 1));
        uart_wrn = !(r_state == U_WPUL);
        uart_rdn = !(r_state == U_RPUL && r_rd_active);
        w_drive  = (r_state == S_ACC && r_we) || r_state == U_WSET || r_state == U_WPUL;
        m_ack    = (r_state == DONE) && !r_owner_u;
        u_ack    = (r_state == DONE) && r_owner_u;
    end

    assign ram_data = w_drive ? r_wdata : 32'bz;
    assign ram_addr = r_addr;
    assign ram_be_n = r_be_n;
    assign m_rdata  = r_m_rdata;
    assign u_rdata  = r_u_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_owner_u   <= 1'b0;
            r_we        <= 1'b0;
            r_rd_active <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_be_n      <= 4'hF;
            r_m_rdata   <= '0;
            r_u_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_u    <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_u) begin
                        r_owner_u <= 1'b1;
                        r_we      <= u_we;
                        r_wdata   <= {24'b0, u_wdata};
                        r_cnt     <= CW'(UART_PULSE - 1);
                        if (u_sel)
                            r_u_rdata <= {30'b0, uart_dataready, uart_tbre & uart_tsre};
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_u  <= 1'b1;
`endif
                    end else if (m_req) begin
                        r_owner_u <= 1'b0;
                        r_we      <= m_we;
                        r_wdata   <= m_wdata;
                        r_addr    <= m_addr;
                        r_be_n    <= ~m_be;
                        r_cnt     <= CW'(SRAM_WAIT - 1);
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_u  <= 1'b0;
`endif
                    end
                end
                S_ACC: begin
                    if (r_cnt == '0) begin
                        if (!r_we) r_m_rdata <= ram_data;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                U_WPUL: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                U_RPUL: begin
                    if (!r_rd_active) begin
                        if (uart_dataready) r_rd_active <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_u_rdata   <= {24'b0, ram_data[7:0]};
                        r_rd_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
